vending_change_fsm: RTL and testbench



---
 rtl/vending_pkg.sv | 25 ++
 rtl/vending_change_gen.sv | 48 ++++
 rtl/vending_change_fsm.sv | 109 ++++++++++
 tb/tb_vending_change_fsm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared coin encodings, FSM state type and coin valuation for the vending FSM family.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CREDIT = 2'b01,
    VEND   = 2'b10,
    CHANGE = 2'b11
  } state_t;

  function automatic logic [4:0] coin_value(input logic [1:0] coin);
    case (coin)
      COIN_5:  return 5'd5;
      COIN_10: return 5'd10;
      COIN_25: return 5'd25;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_change_gen.sv
// Loadable down-counter that pays out an amount as 10c/5c coins, one per step.
module vending_change_gen
  import vending_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  input  logic         i_step,
  output logic [1:0]   o_coin,
  output logic [W-1:0] o_remain,
  output logic         o_done
);

  localparam logic [W-1:0] TEN  = W'(10);
  localparam logic [W-1:0] FIVE = W'(5);

  logic [W-1:0] r_remain;
  logic [1:0]   r_coin;

  // Amounts are always multiples of 5, so the 5c branch never underflows.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remain <= '0;
      r_coin   <= COIN_NONE;
    end else if (i_load) begin
      r_remain <= i_load_value;
      r_coin   <= COIN_NONE;
    end else if (i_step && (r_remain != '0)) begin
      if (r_remain >= TEN) begin
        r_remain <= r_remain - TEN;
        r_coin   <= COIN_10;
      end else begin
        r_remain <= r_remain - FIVE;
        r_coin   <= COIN_5;
      end
    end else begin
      r_coin <= COIN_NONE;
    end
  end

  assign o_coin   = r_coin;
  assign o_remain = r_remain;
  assign o_done   = (r_remain == '0);

endmodule

// File: rtl/vending_change_fsm.sv
// Coin-accepting vending controller: configurable price, cancel/refund, change paid one coin per cycle.
module vending_change_fsm
  import vending_pkg::*;
#(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                dispense,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_dispense;
  logic                r_coin_reject;

  logic [CREDIT_W-1:0] w_credit_sum;
  logic [CREDIT_W-1:0] w_remainder;
  logic                w_coin_valid;
  logic                w_load;
  logic [CREDIT_W-1:0] w_load_value;
  logic                w_step;
  logic [1:0]          w_chg_coin;
  logic [CREDIT_W-1:0] w_chg_remain;
  logic                w_chg_done;

  assign w_coin_valid = (coin != COIN_NONE);
  assign w_credit_sum = r_credit + CREDIT_W'(coin_value(coin));
  assign w_remainder  = r_credit - PRICE_C;

  // The change generator takes over the balance on a refund or an overpaid vend.
  assign w_load       = ((r_state == CREDIT) && cancel) ||
                        ((r_state == VEND) && (w_remainder != '0));
  assign w_load_value = (r_state == VEND) ? w_remainder : r_credit;
  assign w_step       = (r_state == CHANGE);

  vending_change_gen #(
    .W (CREDIT_W)
  ) u_change_gen (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .i_step       (w_step),
    .o_coin       (w_chg_coin),
    .o_remain     (w_chg_remain),
    .o_done       (w_chg_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_dispense    <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_dispense    <= 1'b0;
      r_coin_reject <= 1'b0;
      case (r_state)
        IDLE, CREDIT: begin
          if (cancel) begin
            r_coin_reject <= w_coin_valid;
            if (r_state == CREDIT) begin
              r_state  <= CHANGE;
              r_credit <= '0;
            end
          end else if (w_coin_valid) begin
            r_credit <= w_credit_sum;
            if (w_credit_sum >= PRICE_C) begin
              r_state    <= VEND;
              r_dispense <= 1'b1;
            end else begin
              r_state <= CREDIT;
            end
          end
        end
        VEND: begin
          r_coin_reject <= w_coin_valid;
          r_credit      <= '0;
          r_state       <= (w_remainder == '0) ? IDLE : CHANGE;
        end
        CHANGE: begin
          r_coin_reject <= w_coin_valid;
          if (w_chg_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // While paying out, the visible credit is the balance still owed.
  assign credit      = (r_state == CHANGE) ? w_chg_remain : r_credit;
  assign dispense    = r_dispense;
  assign change_coin = w_chg_coin;
  assign coin_reject = r_coin_reject;
  assign busy        = (r_state == VEND) || (r_state == CHANGE);

endmodule

// File: tb/tb_vending_change_fsm.sv
// Bench for vending_change_fsm: PRICE=15 and PRICE=30 instances share one directed stimulus stream.
module tb_vending_change_fsm;

  typedef struct packed {
    logic       disp;
    logic [1:0] chg;
    logic [7:0] credit;
    logic       busy;
  } entry_t;

  logic       clk;
  logic       reset;
  logic [1:0] coin;
  logic       cancel;

  logic       dispense_w [2];
  logic [1:0] chg_w      [2];
  logic       reject_w   [2];
  logic [5:0] credit_w   [2];
  logic       busy_w     [2];

  int n_pass;
  int n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic int cents(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 25;
      default: return 0;
    endcase
  endfunction

  function automatic entry_t mk(input logic d, input logic [1:0] c, input int cr, input logic b);
    entry_t e;
    e.disp   = d;
    e.chg    = c;
    e.credit = 8'(cr);
    e.busy   = b;
    return e;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int P = (gi == 0) ? 15 : 30;

    vending_change_fsm #(.PRICE(P), .CREDIT_W(6)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .coin        (coin),
      .cancel      (cancel),
      .dispense    (dispense_w[gi]),
      .change_coin (chg_w[gi]),
      .coin_reject (reject_w[gi]),
      .credit      (credit_w[gi]),
      .busy        (busy_w[gi])
    );

    // Model: each purchase or refund is planned as a timeline of future output cycles.
    entry_t q[$];
    entry_t cur;
    logic   exp_rej;
    int     m_credit;
    bit     valid;

    task automatic plan_change(input int amount);
      int amt = amount;
      int c;
      if (amt > 0) begin
        q.push_back(mk(1'b0, 2'b00, amt, 1'b1));
        while (amt > 0) begin
          c = (amt >= 10) ? 10 : 5;
          amt -= c;
          q.push_back(mk(1'b0, (c == 10) ? 2'b10 : 2'b01, amt, 1'b1));
        end
      end
    endtask

    initial begin
      cur = '0; exp_rej = 1'b0; m_credit = 0; valid = 0;
      forever begin
        @(posedge clk);
        if (reset) begin
          q.delete();
          cur = '0; m_credit = 0; exp_rej = 1'b0; valid = 1;
        end else begin
          exp_rej = 1'b0;
          if (cur.busy) begin
            exp_rej = (coin != 2'b00);
            cur = (q.size() > 0) ? q.pop_front() : '0;
          end else if (cancel) begin
            exp_rej = (coin != 2'b00);
            if (m_credit > 0) begin
              plan_change(m_credit);
              m_credit = 0;
              cur = q.pop_front();
            end
          end else if (coin != 2'b00) begin
            m_credit += cents(coin);
            if (m_credit >= P) begin
              q.push_back(mk(1'b1, 2'b00, m_credit, 1'b1));
              plan_change(m_credit - P);
              m_credit = 0;
              cur = q.pop_front();
            end else begin
              cur = mk(1'b0, 2'b00, m_credit, 1'b0);
            end
          end
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        if (valid) begin
          chk($sformatf("i%0d dispense", gi), int'(dispense_w[gi]), int'(cur.disp));
          chk($sformatf("i%0d change_coin", gi), int'(chg_w[gi]), int'(cur.chg));
          chk($sformatf("i%0d coin_reject", gi), int'(reject_w[gi]), int'(exp_rej));
          chk($sformatf("i%0d credit", gi), int'(credit_w[gi]), int'(cur.credit));
          chk($sformatf("i%0d busy", gi), int'(busy_w[gi]), int'(cur.busy));
        end
      end
    end
  end

  task automatic cyc(input logic [1:0] c, input logic x, input logic r);
    coin = c; cancel = x; reset = r;
    @(negedge clk);
    $display("t=%0t coin=%0d cancel=%0d reset=%0d | p15 disp=%0d chg=%0d rej=%0d cr=%0d busy=%0d | p30 disp=%0d chg=%0d rej=%0d cr=%0d busy=%0d",
             $time, c, x, r, dispense_w[0], chg_w[0], reject_w[0], credit_w[0], busy_w[0],
             dispense_w[1], chg_w[1], reject_w[1], credit_w[1], busy_w[1]);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; coin = 2'b00; cancel = 1'b0;
    @(negedge clk);
    cyc(2'b00, 1'b0, 1'b1);
    cyc(2'b00, 1'b0, 1'b1);
    chk("reset dispense", int'(dispense_w[0]), 0);
    chk("reset credit", int'(credit_w[0]), 0);
    chk("reset busy", int'(busy_w[0]), 0);
    chk("reset change", int'(chg_w[0]), 0);

    // 5c, idle, 10c: exact price
    cyc(2'b01, 1'b0, 1'b0); chk("t1 credit5", int'(credit_w[0]), 5);
    cyc(2'b00, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0); chk("t1 credit15", int'(credit_w[0]), 15); chk("t1 disp", int'(dispense_w[0]), 1);
    cyc(2'b00, 1'b0, 1'b0); chk("t1 disp off", int'(dispense_w[0]), 0); chk("t1 idle", int'(busy_w[0]), 0);
    cyc(2'b00, 1'b0, 1'b1);

    // single 25c, then a coin right after returning to IDLE
    cyc(2'b11, 1'b0, 1'b0); chk("t2 disp", int'(dispense_w[0]), 1); chk("t2 credit25", int'(credit_w[0]), 25);
    cyc(2'b00, 1'b0, 1'b0); chk("t2 owed", int'(credit_w[0]), 10);
    cyc(2'b00, 1'b0, 1'b0); chk("t2 coin10", int'(chg_w[0]), 2);
    cyc(2'b00, 1'b0, 1'b0); chk("t2 chg off", int'(chg_w[0]), 0); chk("t2 credit0", int'(credit_w[0]), 0);
    cyc(2'b01, 1'b0, 1'b0); chk("t2 next coin", int'(credit_w[0]), 5);
    cyc(2'b00, 1'b0, 1'b1);

    // 10c, 10c: change 5c
    cyc(2'b10, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0); chk("t3 disp", int'(dispense_w[0]), 1);
    cyc(2'b00, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0); chk("t3 coin5", int'(chg_w[0]), 1);
    cyc(2'b00, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b1);

    // 25c, 10c: PRICE=30 vends with 5c change; PRICE=15 rejects the 10c
    cyc(2'b11, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0); chk("t3b p30 disp", int'(dispense_w[1]), 1); chk("t3b p15 reject", int'(reject_w[0]), 1);
    cyc(2'b00, 1'b0, 1'b0); chk("t3b p30 owed", int'(credit_w[1]), 5);
    cyc(2'b00, 1'b0, 1'b0); chk("t3b p30 coin5", int'(chg_w[1]), 1);
    cyc(2'b00, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b1);

    // 5c, 5c, cancel: full refund
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b00, 1'b1, 1'b0); chk("t4 busy", int'(busy_w[0]), 1); chk("t4 credit10", int'(credit_w[0]), 10);
    cyc(2'b00, 1'b0, 1'b0); chk("t4 refund10", int'(chg_w[0]), 2); chk("t4 disp", int'(dispense_w[0]), 0);
    cyc(2'b00, 1'b0, 1'b0); chk("t4 idle", int'(busy_w[0]), 0);
    cyc(2'b00, 1'b0, 1'b1);

    // 10c then 25c, 5c inserted during VEND
    cyc(2'b10, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 1'b0); chk("t5 credit35", int'(credit_w[0]), 35);
    cyc(2'b01, 1'b0, 1'b0); chk("t5 reject", int'(reject_w[0]), 1); chk("t5 owed20", int'(credit_w[0]), 20);
    cyc(2'b00, 1'b0, 1'b0); chk("t5 first10", int'(chg_w[0]), 2); chk("t5 reject off", int'(reject_w[0]), 0);
    cyc(2'b00, 1'b0, 1'b0); chk("t5 second10", int'(chg_w[0]), 2); chk("t5 owed0", int'(credit_w[0]), 0);
    cyc(2'b00, 1'b0, 1'b0); chk("t5 done", int'(chg_w[0]), 0);
    cyc(2'b00, 1'b0, 1'b1);

    // reset during CHANGE, then coin+cancel in CREDIT
    cyc(2'b11, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0); chk("t6 in change", int'(busy_w[0]), 1);
    cyc(2'b00, 1'b0, 1'b1); chk("t6 reset busy", int'(busy_w[0]), 0); chk("t6 reset credit", int'(credit_w[0]), 0);
    cyc(2'b00, 1'b0, 1'b0); chk("t6 no coin", int'(chg_w[0]), 0);
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b10, 1'b1, 1'b0); chk("t6 cc reject", int'(reject_w[0]), 1); chk("t6 cc credit", int'(credit_w[0]), 5);
    cyc(2'b00, 1'b0, 1'b0); chk("t6 refund5", int'(chg_w[0]), 1);
    cyc(2'b00, 1'b0, 1'b0); chk("t6 idle", int'(busy_w[0]), 0);
    cyc(2'b00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
